counter_timeslot_arbiter: RTL and testbench
===========================================

// Module: counter_timeslot_arbiter
// PURPOSE
//  Shares one WIDTH-bit up-counter between two requesters, each needing a timed interval.
//  Grants round-robin, clears and runs the shared counter until it reaches the granted
//  requester's terminal value, then pulses that requester's done and releases the counter.
//  Sits between client FSMs and the counter datapath; the counter is internal to this block.
// PARAMETERS
//  WIDTH  4  counter and terminal-value width in bits
// PORTS
//  clk    in   1      clock, all state updates on posedge
//  rst    in   1      reset, asynchronous, active-low (0 = reset)
//  req0   in   1      requester 0 wants an interval; held high until done0 or abandoned
//  term0  in   WIDTH  requester 0 terminal count, sampled only at grant
//  req1   in   1      requester 1 request, same rules as req0
//  term1  in   WIDTH  requester 1 terminal count, sampled only at grant
//  abort  in   1      kill current interval, synchronous, no done issued
//  gnt0   out  1      counter owned by requester 0 (registered)
//  gnt1   out  1      counter owned by requester 1 (registered)
//  busy   out  1      1 whenever state != IDLE (registered)
//  count  out  WIDTH  shared counter value (registered)
//  done0  out  1      1-cycle pulse: requester 0 interval complete
//  done1  out  1      1-cycle pulse: requester 1 interval complete
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE, count=0, gnt0/gnt1/busy/done0/done1=0, rr_last=1 (req0 wins first tie).
//  - States: IDLE, RUN, DONE. gnt0 and gnt1 never both 1.
//  - IDLE: no req -> stay, count holds. Any req -> RUN next edge: gnt_x=1, count=0, term_x latched.
//    Both req -> grant the one NOT equal to rr_last. Only one req -> grant it regardless of rr_last.
//  - RUN: count==term_lat -> DONE (count holds); else count<=count+1.
//    Owner's req dropped in RUN, or abort=1 -> IDLE: gnt=0, count holds, no done, rr_last<=owner.
//    abort takes priority over terminal match on the same cycle.
//  - DONE (exactly 1 cycle): done_owner=1, gnt=0, busy=1, rr_last<=owner; next edge -> IDLE.
//    done pulses regardless of req state in DONE; abort in DONE is ignored.
//  - Latency: req sampled high in IDLE at edge k -> gnt=1,count=0 after edge k+1; count==term
//    after edge k+1+term; done=1 after edge k+2+term; next grant no earlier than edge k+4+term.
//  - term=0: RUN one cycle with count=0, then DONE. term=2^WIDTH-1: counter reaches max, never wraps.
//  - term_x changes after grant are ignored; abort in IDLE has no effect.
//  - Counter is unsigned, WIDTH bits, increments only in RUN; no wrap reachable by construction.
// TESTING
//  1 Reset: rst=0 mid-RUN with count=5 -> outputs all 0 immediately, no clk edge needed.
//  2 req0=1,term0=3 alone -> gnt0 next cycle, count 0,1,2,3, then done0 one cycle, gnt0=0, busy=0 after.
//  3 req0=req1=1 from reset, term0=2,term1=1 -> req0 served first (done0), then req1 (done1); repeat -> alternates.
//  4 term1=0 -> gnt1 for 1 cycle with count=0, done1 next cycle; WIDTH=4,term0=15 -> count ends at 15, no wrap.
//  5 req0 interval, abort=1 at count=2 -> IDLE next edge, done0 never asserted, pending req1 granted next.
//  6 req1 dropped at count=1 -> IDLE, no done1; term0 changed mid-RUN -> original latched term still used.

Source files
------------

// File: rtl/counter_timeslot_arbiter_if.sv
// Request/grant bundle between two client FSMs and the shared-counter arbiter.
// The client side drives the requests; the arbiter drives grants, count and done pulses.
interface counter_timeslot_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic [WIDTH-1:0] term0;
  logic             req1;
  logic [WIDTH-1:0] term1;
  logic             abort;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic [WIDTH-1:0] count;
  logic             done0;
  logic             done1;

  modport master (
    output req0, term0, req1, term1, abort,
    input  gnt0, gnt1, busy, count, done0, done1
  );

  modport slave (
    input  req0, term0, req1, term1, abort,
    output gnt0, gnt1, busy, count, done0, done1
  );
endinterface

// File: rtl/counter_timeslot_arbiter.sv
// Round-robin arbiter that lends one internal up-counter to two requesters.
// The granted requester's interval is timed from 0 up to its latched terminal value.
module counter_timeslot_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  counter_timeslot_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [1:0]       gnt_reg;
  logic [1:0]       done_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] term_lat_reg;
  logic             owner_reg;
  logic             rr_last_reg;

  logic [1:0]       req_vec;
  logic [WIDTH-1:0] term_vec [2];
  logic [1:0]       pick_onehot;
  logic [1:0]       owner_onehot;
  logic             any_req;
  logic             pick_next;
  logic             owner_req;
  logic             term_hit;

  assign req_vec = {bus.req1, bus.req0};
  assign term_vec[0] = bus.term0;
  assign term_vec[1] = bus.term1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_onehot
      assign pick_onehot[gi]  = (pick_next == 1'(gi));
      assign owner_onehot[gi] = (owner_reg == 1'(gi));
    end
  endgenerate

  // On a tie the requester that did not own the counter last goes first.
  always_comb begin
    any_req   = |req_vec;
    pick_next = (&req_vec) ? ~rr_last_reg : req_vec[1];
    owner_req = req_vec[owner_reg];
    term_hit  = (count_reg == term_lat_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= 2'b00;
      done_reg     <= 2'b00;
      busy_reg     <= 1'b0;
      count_reg    <= '0;
      term_lat_reg <= '0;
      owner_reg    <= 1'b0;
      rr_last_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 2'b00;
          if (any_req) begin
            state_reg    <= RUN;
            owner_reg    <= pick_next;
            gnt_reg      <= pick_onehot;
            busy_reg     <= 1'b1;
            count_reg    <= '0;
            term_lat_reg <= term_vec[pick_next];
          end
        end
        RUN: begin
          // Abandonment beats a terminal match; the count is left as-is for inspection.
          if (bus.abort || !owner_req) begin
            state_reg   <= IDLE;
            gnt_reg     <= 2'b00;
            busy_reg    <= 1'b0;
            rr_last_reg <= owner_reg;
          end else if (term_hit) begin
            state_reg   <= DONE;
            gnt_reg     <= 2'b00;
            done_reg    <= owner_onehot;
            rr_last_reg <= owner_reg;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          done_reg  <= 2'b00;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 2'b00;
          done_reg  <= 2'b00;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0  = gnt_reg[0];
  assign bus.gnt1  = gnt_reg[1];
  assign bus.done0 = done_reg[0];
  assign bus.done1 = done_reg[1];
  assign bus.busy  = busy_reg;
  assign bus.count = count_reg;

endmodule

// File: tb/tb_counter_timeslot_arbiter.sv
// Directed bench for counter_timeslot_arbiter: an interval-age model is checked every cycle,
// plus literal expectations at hand-computed points of each scenario.
module tb_counter_timeslot_arbiter;

  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  counter_timeslot_arbiter_if #(.WIDTH(WIDTH)) bus ();

  counter_timeslot_arbiter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an active interval is described by its owner, its age since grant and its
  // latched terminal; ages 0..t are the counting phase, age t+1 is the done cycle.
  int m_active = 0;
  int m_own    = 0;
  int m_age    = 0;
  int m_t      = 0;
  int m_last   = 1;
  int m_hold   = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 0;
      m_own    <= 0;
      m_age    <= 0;
      m_t      <= 0;
      m_last   <= 1;
      m_hold   <= 0;
    end else if (m_active != 0) begin
      if (m_age <= m_t) begin
        if (bus.abort || !((m_own == 0) ? bus.req0 : bus.req1)) begin
          m_active <= 0;
          m_last   <= m_own;
          m_hold   <= m_age;
        end else begin
          m_age <= m_age + 1;
        end
      end else begin
        m_active <= 0;
        m_last   <= m_own;
        m_hold   <= m_t;
      end
    end else if (bus.req0 || bus.req1) begin
      automatic int pick;
      if (bus.req0 && bus.req1) pick = (m_last == 0) ? 1 : 0;
      else                      pick = bus.req0 ? 0 : 1;
      m_active <= 1;
      m_own    <= pick;
      m_age    <= 0;
      m_t      <= (pick == 0) ? int'(bus.term0) : int'(bus.term1);
    end
  end

  function automatic int exp_count();
    if (m_active == 0) return m_hold;
    return (m_age <= m_t) ? m_age : m_t;
  endfunction

  function automatic int exp_gnt(input int who);
    return (m_active != 0 && m_age <= m_t && m_own == who) ? 1 : 0;
  endfunction

  function automatic int exp_done(input int who);
    return (m_active != 0 && m_age == m_t + 1 && m_own == who) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("model_gnt0",  int'(bus.gnt0),  exp_gnt(0));
      check("model_gnt1",  int'(bus.gnt1),  exp_gnt(1));
      check("model_done0", int'(bus.done0), exp_done(0));
      check("model_done1", int'(bus.done1), exp_done(1));
      check("model_busy",  int'(bus.busy),  m_active);
      check("model_count", int'(bus.count), exp_count());
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.term0 = '0;
    bus.term1 = '0;
    bus.abort = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #3;
    check("rst_busy",  int'(bus.busy),  0);
    check("rst_gnt0",  int'(bus.gnt0),  0);
    check("rst_count", int'(bus.count), 0);
    @(negedge clk);
    rst = 1'b1;

    // Single requester, term 3
    bus.term0 = 4'd3;
    bus.req0  = 1'b1;
    tick();
    check("t2_gnt0", int'(bus.gnt0), 1);
    check("t2_cnt0", int'(bus.count), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("t2_cnt", int'(bus.count), i);
    end
    tick();
    check("t2_done0", int'(bus.done0), 1);
    check("t2_gnt0_off", int'(bus.gnt0), 0);
    check("t2_busy_done", int'(bus.busy), 1);
    bus.req0 = 1'b0;
    tick();
    check("t2_idle_busy", int'(bus.busy), 0);
    $display("txn: req0 term=3 interval complete");

    // Asynchronous reset in the middle of an interval
    bus.term0 = 4'd9;
    bus.req0  = 1'b1;
    tick();
    repeat (5) tick();
    check("t1_cnt5", int'(bus.count), 5);
    #2 rst = 1'b0;
    #1;
    check("t1_busy", int'(bus.busy), 0);
    check("t1_gnt0", int'(bus.gnt0), 0);
    check("t1_count", int'(bus.count), 0);
    bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("txn: reset asserted at count=5");

    // Simultaneous requests alternate, req0 first
    bus.term0 = 4'd2;
    bus.term1 = 4'd1;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    tick();
    check("t3_first_gnt0", int'(bus.gnt0), 1);
    tick(); tick(); tick();
    check("t3_done0", int'(bus.done0), 1);
    tick(); tick();
    check("t3_gnt1", int'(bus.gnt1), 1);
    tick(); tick();
    check("t3_done1", int'(bus.done1), 1);
    tick(); tick();
    check("t3_gnt0_again", int'(bus.gnt0), 1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    tick();
    check("t3_drop_busy", int'(bus.busy), 0);
    $display("txn: tied requests served 0,1,0");

    // term=0, abort during DONE, then full-range term with abort held in IDLE
    bus.term1 = 4'd0;
    bus.req1  = 1'b1;
    tick();
    check("t4_gnt1", int'(bus.gnt1), 1);
    tick();
    check("t4_done1", int'(bus.done1), 1);
    bus.abort = 1'b1;
    bus.req1  = 1'b0;
    tick();
    bus.term0 = 4'd15;
    bus.req0  = 1'b1;
    tick();
    check("t4_abort_idle_gnt0", int'(bus.gnt0), 1);
    bus.abort = 1'b0;
    repeat (15) tick();
    check("t4_cnt15", int'(bus.count), 15);
    tick();
    check("t4_done0", int'(bus.done0), 1);
    check("t4_cnt_hold", int'(bus.count), 15);
    bus.req0 = 1'b0;
    tick();
    check("t4_nowrap", int'(bus.count), 15);
    $display("txn: term1=0 and term0=15 intervals complete");

    // Abort at count 2 with req1 pending
    bus.term0 = 4'd6;
    bus.req0  = 1'b1;
    tick();
    bus.term1 = 4'd2;
    bus.req1  = 1'b1;
    tick(); tick();
    check("t5_cnt2", int'(bus.count), 2);
    bus.abort = 1'b1;
    tick();
    check("t5_abort_gnt0", int'(bus.gnt0), 0);
    check("t5_abort_done0", int'(bus.done0), 0);
    check("t5_abort_cnt", int'(bus.count), 2);
    bus.abort = 1'b0;
    tick();
    check("t5_next_gnt1", int'(bus.gnt1), 1);
    $display("txn: req0 aborted at count=2, req1 granted");

    // req1 dropped at count 1; term0 changed after grant
    tick();
    check("t6_cnt1", int'(bus.count), 1);
    bus.req1 = 1'b0;
    tick();
    check("t6_drop_done1", int'(bus.done1), 0);
    check("t6_drop_busy", int'(bus.busy), 0);
    tick();
    check("t6_gnt0", int'(bus.gnt0), 1);
    bus.term0 = 4'd1;
    repeat (6) tick();
    check("t6_cnt6", int'(bus.count), 6);
    tick();
    check("t6_done0", int'(bus.done0), 1);
    bus.req0 = 1'b0;
    tick();
    $display("txn: req1 dropped, req0 ran latched term=6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
